// File: rtl/gamepad_pmod_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gamepad_pmod_pkg
// Description : Shared constants, button map, FSM state encoding and the
//               absent-pad substitution helper for the Gamepad Pmod
//               transmit driver.
// Revision    : 1.0 - initial release
// ============================================================================
package gamepad_pmod_pkg;

    localparam int BITS_PER_PAD = 12;
    localparam int NUM_PADS     = 2;
    localparam int FRAME_BITS   = BITS_PER_PAD * NUM_PADS;

    // An unplugged controller reads as every button pressed on the wire.
    localparam logic [BITS_PER_PAD-1:0] ABSENT_WORD = 12'hFFF;

    // Bit positions inside one 12-bit pad word.
    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BIT_LO = 3'd1,
        ST_BIT_HI = 3'd2,
        ST_LATCH  = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    function automatic logic [BITS_PER_PAD-1:0] pad_word(
        input logic                    present,
        input logic [BITS_PER_PAD-1:0] buttons
    );
        return present ? buttons : ABSENT_WORD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gamepad_pmod_tick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gamepad_pmod_tick
// Description : Loadable down-counter with a one-cycle terminal pulse.
//               Loading N-1 on state entry makes o_done fire on the Nth
//               cycle of that state. o_done_next warns one cycle ahead so a
//               caller can register an output that lines up with o_done.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_load            - reload the counter (wins over counting)
//               i_load_value      - value loaded on i_load
//               o_done            - counter armed and at zero
//               o_done_next       - o_done will be high next cycle (no load)
// Revision    : 1.0 - initial release
// ============================================================================
module gamepad_pmod_tick #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_done,
    output logic             o_done_next
);

    logic [WIDTH-1:0] r_count;
    logic             r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_value;
            r_armed <= 1'b1;
        end else if (r_armed) begin
            // Disarm after the terminal cycle so the pulse is a single cycle.
            if (r_count == '0) begin
                r_armed <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_done      = r_armed && (r_count == '0);
    assign o_done_next = r_armed && (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/gamepad_pmod_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gamepad_pmod_driver
// Description : Transmit side of the Gamepad Pmod serial link. Snapshots two
//               12-bit pad words and shifts them MSB first on pmod_data with
//               pmod_clk, then pulses pmod_latch to commit the frame.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               enable             - start a frame when idle (hold = repeat)
//               buttons1/2         - pad button states, active-high
//               present1/2         - pad connected; absent pads send 12'hFFF
//               pmod_data/clk/latch- serial link outputs (registered)
//               busy               - any state other than IDLE
//               frame_done         - pulse on the last latch cycle
// Revision    : 1.0 - initial release
// ============================================================================
module gamepad_pmod_driver
    import gamepad_pmod_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] buttons1,
    input  logic [11:0] buttons2,
    input  logic        present1,
    input  logic        present2,
    output logic        pmod_data,
    output logic        pmod_clk,
    output logic        pmod_latch,
    output logic        busy,
    output logic        frame_done
);

    // The receiver's 2-flop synchronizers need at least 3 cycles per level.
    generate
        if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_clk_div_check
            $error("gamepad_pmod_driver: CLK_DIV must be in 3..255");
        end
        if (GAP_CYCLES > 65535) begin : g_gap_check
            $error("gamepad_pmod_driver: GAP_CYCLES must be in 0..65535");
        end
    endgenerate

    localparam logic [15:0] c_HALF_LOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_GAP_LOAD  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam logic [4:0]  c_LAST_BIT  = 5'(FRAME_BITS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [FRAME_BITS-1:0] w_shreg_next;
    logic [4:0]            r_bit_cnt;
    logic [4:0]            w_bit_cnt_next;

    logic                  w_load;
    logic [15:0]           w_load_value;
    logic                  w_tick_done;
    logic                  w_tick_done_next;

    logic                  r_pmod_data;
    logic                  r_pmod_clk;
    logic                  r_pmod_latch;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  w_data_next;
    logic                  w_clk_next;
    logic                  w_latch_next;
    logic                  w_busy_next;
    logic                  w_frame_done_next;

    gamepad_pmod_tick #(
        .WIDTH (16)
    ) u_tick (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .o_done       (w_tick_done),
        .o_done_next  (w_tick_done_next)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_pmod_data  <= 1'b0;
            r_pmod_clk   <= 1'b0;
            r_pmod_latch <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shreg      <= w_shreg_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_pmod_data  <= w_data_next;
            r_pmod_clk   <= w_clk_next;
            r_pmod_latch <= w_latch_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    // Next-state logic. Outputs are decoded from the next state so that the
    // registered outputs line up exactly with the state they describe.
    always_comb begin
        w_state_next   = r_state;
        w_shreg_next   = r_shreg;
        w_bit_cnt_next = r_bit_cnt;
        w_load         = 1'b0;
        w_load_value   = c_HALF_LOAD;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_shreg_next   = {pad_word(present1, buttons1),
                                      pad_word(present2, buttons2)};
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_BIT_LO;
                    w_load         = 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (w_tick_done) begin
                    w_state_next = ST_BIT_HI;
                    w_load       = 1'b1;
                end
            end
            ST_BIT_HI: begin
                if (w_tick_done) begin
                    w_shreg_next   = {r_shreg[FRAME_BITS-2:0], 1'b0};
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    w_state_next   = (r_bit_cnt == c_LAST_BIT) ? ST_LATCH : ST_BIT_LO;
                    w_load         = 1'b1;
                end
            end
            ST_LATCH: begin
                if (w_tick_done) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_GAP;
                        w_load       = 1'b1;
                        w_load_value = c_GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // The shift register only moves when leaving BIT_HI, so data is
        // stable across each BIT_LO/BIT_HI pair and changes on BIT_LO entry.
        w_data_next       = ((w_state_next == ST_BIT_LO) || (w_state_next == ST_BIT_HI))
                            ? w_shreg_next[FRAME_BITS-1] : 1'b0;
        w_clk_next        = (w_state_next == ST_BIT_HI);
        w_latch_next      = (w_state_next == ST_LATCH);
        w_busy_next       = (w_state_next != ST_IDLE);
        // Fires one cycle early so the registered pulse marks the last
        // latch cycle (the tick's terminal cycle).
        w_frame_done_next = (r_state == ST_LATCH) && w_tick_done_next;
    end

    assign pmod_data  = r_pmod_data;
    assign pmod_clk   = r_pmod_clk;
    assign pmod_latch = r_pmod_latch;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
